imem_arbiter: RTL

Single-port arbiter and sequencer in front of the byte-addressed instruction memory. Shares the memory between the IF-stage fetch port and a boot/debug loader write port, gating fetch until program load completes. Handles branch flushes of in-flight reads and misaligned fetch addresses, so the pipeline sees a clean valid/ready fetch interface.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter: state encoding,
// NOP filler word for misaligned fetches and the default address width.
package imem_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } imem_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          ADDR_W_DEF = 20;

    function automatic logic is_aligned(input logic [1:0] byte_off);
        return (byte_off == 2'b00);
    endfunction

endpackage

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: loader writes during boot, then
// fetch/loader arbitration with a starvation guard, flush and misalign handling.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_BOOT | program load in progress; only the loader may touch memory
// ST_RUN  | fetch enabled; loader still accepted under starvation guard
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_ready,
    input  logic              f_flush,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_err,
    input  logic              l_req,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_ready,
    input  logic              l_done,
    output logic              mem_cs_n,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    imem_state_t r_state;
    imem_state_t w_state_nxt;
    logic [3:0]  r_starve_cnt;
    logic        r_rd_pend;
    logic        r_mis_pend;

    logic        w_l_gnt;
    logic        w_f_gnt;
    logic        w_f_aligned;
    logic        w_rvalid;
    logic        w_unused;

    assign w_f_aligned = is_aligned(f_addr[1:0]);
    assign w_unused    = ^{l_addr[31:ADDR_W], l_addr[1:0], f_addr[31:ADDR_W]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_BOOT && l_done) begin
            w_state_nxt = ST_RUN;
        end
    end

    // Grants are suppressed while reset is held so the idle values are seen
    // during the reset cycle itself, not only after it.
    always_comb begin
        w_l_gnt = 1'b0;
        w_f_gnt = 1'b0;
        if (rst) begin
            if (r_state == ST_BOOT) begin
                w_l_gnt = l_req;
            end else if (l_req && f_req) begin
                if (r_starve_cnt == STARVE_LIM) begin
                    w_f_gnt = 1'b1;
                end else begin
                    w_l_gnt = 1'b1;
                end
            end else begin
                w_l_gnt = l_req;
                w_f_gnt = f_req;
            end
        end
    end

    assign f_ready = w_f_gnt;
    assign l_ready = w_l_gnt;

    always_comb begin
        mem_cs_n  = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_l_gnt) begin
            mem_cs_n  = 1'b0;
            mem_we    = 1'b1;
            mem_addr  = {l_addr[ADDR_W-1:2], 2'b00};
            mem_wdata = l_wdata;
        end else if (w_f_gnt && w_f_aligned) begin
            mem_cs_n  = 1'b0;
            mem_addr  = {f_addr[ADDR_W-1:2], 2'b00};
        end
    end

    // Saturates at the limit so a long boot with fetch waiting cannot wrap
    // the counter past the compare value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (w_f_gnt || !f_req) begin
            r_starve_cnt <= '0;
        end else if (w_l_gnt && r_starve_cnt != STARVE_LIM) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_pend  <= 1'b0;
            r_mis_pend <= 1'b0;
        end else begin
            r_rd_pend  <= w_f_gnt && w_f_aligned;
            r_mis_pend <= w_f_gnt && !w_f_aligned;
        end
    end

    // The memory returns data the cycle after the access, so the response is
    // formed from the pending flags with the live flush and reset as kills.
    assign w_rvalid = rst && !f_flush && (r_rd_pend || r_mis_pend);

    assign f_rvalid = w_rvalid;
    assign f_err    = w_rvalid && r_mis_pend;

    always_comb begin
        f_rdata = '0;
        if (w_rvalid) begin
            f_rdata = r_mis_pend ? NOP_INSTR : mem_rdata;
        end
    end

endmodule
